// File: rtl/axilite_csr_write_ctrl.sv
// AXI4-Lite write-channel controller: sequences AW/W/B, range-checks the
// address and issues a one-cycle write command to the CSR register file.
module axilite_csr_write_ctrl #(
  parameter int         ADDR_SIZE   = 32,
  parameter int         DATA_WIDTH  = 32,
  parameter int         DATA_SIZE   = 128,
  parameter logic [1:0] RESP_OKAY   = 2'd0,
  parameter logic [1:0] RESP_SLVERR = 2'd2,
  localparam int        NWORDS      = DATA_SIZE / DATA_WIDTH,
  localparam int        IDXW        = (NWORDS > 1) ? $clog2(NWORDS) : 1,
  localparam int        STRBW       = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_SIZE-1:0]  awaddr,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [STRBW-1:0]      wstrb,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready,
  output logic                  csr_we,
  output logic [IDXW-1:0]       csr_word_idx,
  output logic [DATA_WIDTH-1:0] csr_wdata,
  output logic [STRBW-1:0]      csr_wstrb,
  output logic [2:0]            dbg_state
);

  localparam int LSB   = $clog2(STRBW);
  localparam int WORDW = ADDR_SIZE - LSB;
  localparam logic [WORDW-1:0] NWORDS_W = WORDW'(NWORDS);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HAVE_AW = 3'd1,
    S_HAVE_W  = 3'd2,
    S_COMMIT  = 3'd3,
    S_RESP    = 3'd4
  } state_t;

  state_t           state;
  logic [WORDW-1:0] word_q;
  logic [WORDW-1:0] word_nxt;
  logic             aw_hs;
  logic             w_hs;
  logic             in_range_q;
  logic             in_range_nxt;

  // Handshake semantics: a channel transfers on a rising clk edge where its
  // valid and ready are both high; B completes on bvalid && bready. The
  // readies decode the state register only, never the incoming valids.
  assign awready   = (state == S_IDLE) || (state == S_HAVE_W);
  assign wready    = (state == S_IDLE) || (state == S_HAVE_AW);
  assign aw_hs     = awvalid && awready;
  assign w_hs      = wvalid && wready;
  assign dbg_state = state;

  // The range check for the csr_we pulse must see an address accepted on
  // the same edge that enters COMMIT, so it looks at the incoming word.
  assign word_nxt     = aw_hs ? awaddr[ADDR_SIZE-1:LSB] : word_q;
  assign in_range_nxt = (word_nxt < NWORDS_W);
  assign in_range_q   = (word_q < NWORDS_W);
  assign csr_word_idx = word_q[IDXW-1:0];

  generate
    if (LSB > 0) begin : g_lsb
      logic unused_addr_lsbs;
      assign unused_addr_lsbs = ^awaddr[LSB-1:0];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      word_q    <= '0;
      csr_wdata <= '0;
      csr_wstrb <= '0;
      csr_we    <= 1'b0;
      bvalid    <= 1'b0;
      bresp     <= RESP_OKAY;
    end else begin
      csr_we <= 1'b0;
      if (aw_hs) word_q <= awaddr[ADDR_SIZE-1:LSB];
      if (w_hs) begin
        csr_wdata <= wdata;
        csr_wstrb <= wstrb;
      end
      case (state)
        S_IDLE: begin
          if (aw_hs && w_hs) begin
            state  <= S_COMMIT;
            csr_we <= in_range_nxt;
          end else if (aw_hs) begin
            state <= S_HAVE_AW;
          end else if (w_hs) begin
            state <= S_HAVE_W;
          end
        end
        S_HAVE_AW: begin
          if (w_hs) begin
            state  <= S_COMMIT;
            csr_we <= in_range_nxt;
          end
        end
        S_HAVE_W: begin
          if (aw_hs) begin
            state  <= S_COMMIT;
            csr_we <= in_range_nxt;
          end
        end
        S_COMMIT: begin
          state  <= S_RESP;
          bvalid <= 1'b1;
          bresp  <= in_range_q ? RESP_OKAY : RESP_SLVERR;
        end
        S_RESP: begin
          if (bready) begin
            state  <= S_IDLE;
            bvalid <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axilite_csr_write_ctrl.sv
// Randomized self-checking bench for axilite_csr_write_ctrl against a
// transaction-level model of address decode, commit and response timing.
module tb_axilite_csr_write_ctrl;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int DS = 128;
  localparam int SW = DW / 8;
  localparam int NW = DS / DW;
  localparam int IW = 2;
  localparam int CW = IW + SW + DW;

  logic          clk;
  logic          rst;
  logic [AW-1:0] awaddr;
  logic          awvalid;
  logic          awready;
  logic [DW-1:0] wdata;
  logic [SW-1:0] wstrb;
  logic          wvalid;
  logic          wready;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready;
  logic          csr_we;
  logic [IW-1:0] csr_word_idx;
  logic [DW-1:0] csr_wdata;
  logic [SW-1:0] csr_wstrb;
  logic [2:0]    dbg_state;

  logic [CW-1:0] exp_q[$];
  logic [1:0]    resp_q[$];
  int n_vec = 0;
  int n_err = 0;

  axilite_csr_write_ctrl #(
    .ADDR_SIZE(AW), .DATA_WIDTH(DW), .DATA_SIZE(DS),
    .RESP_OKAY(2'd0), .RESP_SLVERR(2'd2)
  ) dut (
    .clk(clk), .rst(rst),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .csr_we(csr_we), .csr_word_idx(csr_word_idx),
    .csr_wdata(csr_wdata), .csr_wstrb(csr_wstrb),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // scoreboard: register-file commands and B responses
  always @(negedge clk) begin
    if (!rst) begin
      if (csr_we) begin
        if (exp_q.size() == 0) check("csr_we_unexpected", 1, 0);
        else check("csr_cmd", {csr_word_idx, csr_wstrb, csr_wdata}, exp_q.pop_front());
      end
      if (bvalid && bready) begin
        if (resp_q.size() == 0) check("bresp_unexpected", 1, 0);
        else check("bresp", bresp, resp_q.pop_front());
      end
    end
  end

  // driver: mode 0 = AW and W together, 1 = AW first, 2 = W first
  task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          input logic [SW-1:0] strb, input int mode, input int gap,
                          input int bdelay);
    int unsigned   word;
    bit            in_rng;
    logic [IW-1:0] idx;
    logic [1:0]    resp;
    word   = addr / SW;
    in_rng = (word < NW);
    idx    = IW'(word % NW);
    resp   = in_rng ? 2'd0 : 2'd2;
    if (in_rng) exp_q.push_back({idx, strb, data});
    resp_q.push_back(resp);

    check("idle_ready", {awready, wready}, 2'b11);
    case (mode)
      0: begin
        awaddr = addr; awvalid = 1'b1;
        wdata = data; wstrb = strb; wvalid = 1'b1;
        step();
      end
      1: begin
        awaddr = addr; awvalid = 1'b1;
        step();
        awaddr = $urandom;
        for (int i = 0; i < gap; i++) begin
          check("have_aw_ready", {awready, wready, csr_we}, 3'b010);
          step();
        end
        awvalid = 1'b0;
        wdata = data; wstrb = strb; wvalid = 1'b1;
        step();
      end
      default: begin
        wdata = data; wstrb = strb; wvalid = 1'b1;
        step();
        wdata = $urandom; wstrb = 4'($urandom);
        for (int i = 0; i < gap; i++) begin
          check("have_w_ready", {awready, wready, csr_we}, 3'b100);
          step();
        end
        wvalid = 1'b0;
        awaddr = addr; awvalid = 1'b1;
        step();
      end
    endcase

    awvalid = 1'b0; wvalid = 1'b0;
    check("commit_we", csr_we, in_rng);
    check("commit_out", {bvalid, awready, wready, csr_word_idx, csr_wstrb, csr_wdata},
          {3'b000, idx, strb, data});
    bready = (bdelay == 0);
    step();

    if (bdelay > 0) begin
      awaddr = $urandom; awvalid = 1'b1;
      wdata = $urandom; wvalid = 1'b1;
      for (int i = 0; i < bdelay; i++) begin
        check("resp_hold", {bvalid, bresp, awready, wready, csr_we, csr_word_idx, csr_wstrb, csr_wdata},
              {1'b1, resp, 3'b000, idx, strb, data});
        step();
      end
      awvalid = 1'b0; wvalid = 1'b0;
      bready = 1'b1;
    end
    check("resp_last", {bvalid, bresp, awready, wready, csr_we, csr_word_idx, csr_wstrb, csr_wdata},
          {1'b1, resp, 3'b000, idx, strb, data});
    step();
    bready = 1'b0;
    check("after_resp", {bvalid, csr_we}, 2'b00);
  endtask

  initial begin
    rst = 1'b1; awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0;
    wvalid = 1'b0; bready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_ready", {awready, wready}, 2'b11);
    check("rst_out", {bvalid, bresp, csr_we, csr_word_idx, csr_wstrb, csr_wdata}, '0);
    rst = 1'b0;
    step();

    do_write(32'h4,  32'hDEADBEEF, 4'hF, 0, 0, 0);
    do_write(32'h8,  32'h12345678, 4'h3, 1, 3, 0);
    do_write(32'hC,  32'hA5A5A5A5, 4'hF, 2, 2, 0);
    do_write(32'h10, 32'h0BADF00D, 4'hF, 0, 0, 0);
    do_write(32'h0,  32'h11112222, 4'h5, 0, 0, 5);
    do_write(32'h7,  32'h33334444, 4'hC, 0, 0, 0);
    do_write(32'h4,  32'h55556666, 4'h0, 1, 1, 1);

    for (int n = 0; n < 40; n++)
      do_write(AW'($urandom_range(0, 23)), $urandom, SW'($urandom_range(0, 15)),
               $urandom_range(0, 2), $urandom_range(1, 4), $urandom_range(0, 3));

    // reset while the response is pending
    exp_q.push_back({2'd1, 4'hF, 32'hCAFEF00D});
    awaddr = 32'h4; awvalid = 1'b1; wdata = 32'hCAFEF00D; wstrb = 4'hF; wvalid = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    step();
    check("pre_rst_bvalid", bvalid, 1);
    rst = 1'b1;
    #1;
    check("rst_mid_resp", {bvalid, csr_we, awready, wready}, 4'b0011);
    check("rst_mid_data", {csr_word_idx, csr_wstrb, csr_wdata}, '0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("post_rst_idle", {bvalid, csr_we, awready, wready}, 4'b0011);
    end

    // reset while holding only write data
    wdata = 32'h0F0F0F0F; wstrb = 4'hF; wvalid = 1'b1;
    step();
    wvalid = 1'b0;
    check("have_w_before_rst", {awready, wready}, 2'b10);
    rst = 1'b1;
    #1;
    check("rst_have_w", {awready, wready, bvalid}, 3'b110);
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("post_rst2_idle", {bvalid, csr_we}, 2'b00);
    end

    do_write(32'h8, 32'h77778888, 4'h9, 2, 1, 0);
    repeat (3) step();
    check("exp_q_empty", exp_q.size(), 0);
    check("resp_q_empty", resp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/axilite_csr_write_ctrl.md
Name: axilite_csr_write_ctrl

Overview:
AXI4-Lite write-channel controller for the CSR block. It sequences the AW, W and B channels, latches address, data and strobe, and range-checks the address. It issues a single-cycle write command to the CSR register-file datapath, then returns the write response. It accepts one outstanding write at a time.

Parameters:
ADDR_SIZE, 32, width of awaddr
DATA_WIDTH, 32, AXI data bus width in bits (power of two, >= 8)
DATA_SIZE, 128, total CSR storage in bits (multiple of DATA_WIDTH)
RESP_OKAY, 0, bresp code for a successful write
RESP_SLVERR, 2, bresp code for an out-of-range write

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
awaddr  in  ADDR_SIZE  write address (byte address)
awvalid  in  1  write address valid
awready  out  1  write address ready
wdata  in  DATA_WIDTH  write data
wstrb  in  DATA_WIDTH/8  byte strobes
wvalid  in  1  write data valid
wready  out  1  write data ready
bresp  out  2  write response
bvalid  out  1  write response valid
bready  in  1  write response ready
csr_we  out  1  one-cycle write command to the register file
csr_word_idx  out  IDXW  word index, IDXW = max(1, clog2(DATA_SIZE/DATA_WIDTH))
csr_wdata  out  DATA_WIDTH  latched write data
csr_wstrb  out  DATA_WIDTH/8  latched strobes

Behaviour:
- Reset is asynchronous and active-high. All of the following are forced while rst is high:
  - state = IDLE
  - bvalid = 0, bresp = RESP_OKAY, csr_we = 0
  - latched address, data and strobe = 0
- awready and wready are decoded from the registered state. They follow the IDLE state, so both read 1 after reset; no handshake completes while rst is high.
- States: IDLE, HAVE_AW, HAVE_W, COMMIT, RESP.
- Ready decode:
  - awready = 1 in IDLE and HAVE_W, else 0.
  - wready = 1 in IDLE and HAVE_AW, else 0.
- Handshake rule: a channel transfers on any rising edge where valid and ready are both high. Address is latched on the AW transfer; data and strobe are latched on the W transfer.
- Transitions:
  - IDLE: AW and W in the same cycle -> COMMIT. AW only -> HAVE_AW. W only -> HAVE_W. Neither -> stay.
  - HAVE_AW: W transfer -> COMMIT. Further awvalid is ignored (awready = 0).
  - HAVE_W: AW transfer -> COMMIT. Further wvalid is ignored.
  - COMMIT: lasts exactly one cycle, then -> RESP.
  - RESP: bvalid = 1. On bready -> IDLE, else stay.
- Address decode:
  - LSB = clog2(DATA_WIDTH/8); the low LSB address bits are ignored (unaligned writes are silently aligned down).
  - word = awaddr >> LSB.
  - Out of range when word >= DATA_SIZE/DATA_WIDTH.
  - csr_word_idx = word truncated to IDXW bits.
- COMMIT cycle:
  - In range: csr_we = 1 for exactly this cycle; csr_word_idx, csr_wdata and csr_wstrb hold the latched values; bresp is registered as RESP_OKAY.
  - Out of range: csr_we = 0 and bresp is registered as RESP_SLVERR.
  - csr_wdata, csr_wstrb and csr_word_idx stay stable from COMMIT through the end of RESP.
- wstrb = 0 while in range: csr_we still pulses (no bytes change) and bresp = RESP_OKAY.
- RESP: bresp is stable and bvalid is held until the bready transfer. bvalid deasserts the cycle after the transfer. If bready is already high, bvalid is high for exactly one cycle.
- Latency:
  - AW and W accepted on edge N -> csr_we high during cycle N+1 -> bvalid high from cycle N+2.
  - Fastest back-to-back write: accept to accept every 3 cycles with bready held high.
- Reset mid-operation, in any state: the pending transaction is dropped with no csr_we and no response, bvalid falls immediately, and the FSM restarts in IDLE.
- All outputs except awready and wready are registered. awready and wready are pure decodes of the state register, with no combinational path from input valids.

Test Plan:
1. Same-cycle AW/W: awaddr=0x4, wdata=0xDEADBEEF, wstrb=0xF, bready=1 -> csr_we one cycle after accept with idx=1, csr_wdata=0xDEADBEEF, csr_wstrb=0xF; then bvalid=1, bresp=0 for one cycle; awready=wready=1 again 3 cycles after accept.
2. AW first (awaddr=0x8), W three cycles later (wdata=0x12345678, wstrb=0x3) -> awready=0 and wready=1 while waiting; csr_we with idx=2, csr_wstrb=0x3 the cycle after the W transfer; bresp=0.
3. W first (wdata=0xA5A5A5A5), AW two cycles later (awaddr=0xC) -> wready=0 while waiting; csr_we with idx=3 and the data latched earlier; bresp=0.
4. Out of range: awaddr=0x10 with DATA_SIZE=128 -> csr_we stays 0; bvalid=1 with bresp=2.
5. Backpressure: bready=0 for 5 cycles after bvalid, with awvalid/wvalid asserted for a new write -> bvalid and bresp stable, awready=wready=0, new write not accepted; bready=1 -> IDLE, then the new write is accepted.
6. Unaligned awaddr=0x7 -> idx=1, bresp=0. Separately, assert rst during RESP -> bvalid=0 immediately, csr_we never pulses again for that write, awready=wready=1 after rst is released.
